// File: rtl/matrix_mult_pkg.sv
// Shared types and elaboration-time helpers for the streaming matrix multiplier.
package matrix_mult_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    OUTPUT  = 3'd4,
    DONE    = 3'd5
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Counters and indices need at least one bit even when their range is a single value.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int calc_aw(input int dw, input int k, input int sgn);
    return 2 * dw + clog2(k) + sgn;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: acc restarts on 'first', otherwise accumulates, only when 'en'.
module mac_unit
  import matrix_mult_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 17,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          first,
  input  logic          en,
  output logic [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]        prod_u;
  logic [AW-1:0]          prod_ext;
  logic [AW-1:0]          acc_q, acc_d;

  always_comb begin
    prod_s = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    // A size cast keeps the operand's signedness, so the signed product sign-extends.
    if (SIGNED != 0) prod_ext = AW'(prod_s);
    else             prod_ext = AW'(prod_u);
    acc_d = acc_q;
    if (en) acc_d = first ? prod_ext : acc_q + prod_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matrix_mult_stream.sv
// Streaming MxK * KxN matrix multiplier: serial operand load, K-cycle MAC per element, serial result.
module matrix_mult_stream
  import matrix_mult_pkg::*;
#(
  parameter int DW     = 8,
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int SIGNED = 0,
  parameter int AW     = calc_aw(DW, K, SIGNED)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int AN  = M * K;
  localparam int BN  = K * N;
  localparam int LN  = (AN > BN) ? AN : BN;
  localparam int IW  = cnt_w(M);
  localparam int JW  = cnt_w(N);
  localparam int KW  = cnt_w(K);
  localparam int LW  = cnt_w(LN);
  localparam int AIW = cnt_w(AN);
  localparam int BIW = cnt_w(BN);

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [DW-1:0]   abuf_q [AN];
  logic [DW-1:0]   abuf_d [AN];
  logic [DW-1:0]   bbuf_q [BN];
  logic [DW-1:0]   bbuf_d [BN];
  logic [AIW-1:0]  a_idx;
  logic [BIW-1:0]  b_idx;
  logic            mac_en, mac_first;
  logic [AW-1:0]   acc;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    lcnt_d    = lcnt_q;
    abuf_d    = abuf_q;
    bbuf_d    = bbuf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    mac_en    = 1'b0;
    mac_first = (k_q == '0);
    a_idx     = AIW'(int'(i_q) * K + int'(k_q));
    b_idx     = BIW'(int'(k_q) * N + int'(j_q));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          lcnt_d  = '0;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          abuf_d[lcnt_q[AIW-1:0]] = data_in;
          if (lcnt_q == LW'(AN - 1)) begin
            lcnt_d  = '0;
            state_d = LOAD_B;
          end else begin
            lcnt_d = lcnt_q + LW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bbuf_d[lcnt_q[BIW-1:0]] = data_in;
          if (lcnt_q == LW'(BN - 1)) begin
            lcnt_d  = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = COMPUTE;
          end else begin
            lcnt_d = lcnt_q + LW'(1);
          end
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        if (k_q == KW'(K - 1)) begin
          k_d     = '0;
          state_d = OUTPUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      // The accumulator is idle here, so data_out holds until the sink takes it.
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (i_q == IW'(M - 1) && j_q == JW'(N - 1)) begin
            i_d     = '0;
            j_d     = '0;
            state_d = DONE;
          end else begin
            state_d = COMPUTE;
            if (j_q == JW'(N - 1)) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Operand storage is pure data; every job rewrites it completely before use.
  always_ff @(posedge clk) begin
    abuf_q <= abuf_d;
    bbuf_q <= bbuf_d;
  end

  mac_unit #(
    .DW    (DW),
    .AW    (AW),
    .SIGNED(SIGNED)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .a    (abuf_q[a_idx]),
    .b    (bbuf_q[b_idx]),
    .first(mac_first),
    .en   (mac_en),
    .acc  (acc)
  );

  assign busy     = (state_q != IDLE);
  assign data_out = acc;

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Bench for matrix_mult_stream: three configurations driven through one shared bus selected by 'sel'.
module tb_matrix_mult_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_b, in_valid_b, out_ready_b;
  logic [7:0]  din_b;
  int          sel;

  logic [16:0] dout0;
  logic [17:0] dout1, dout2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2, dn0, dn1, dn2;

  logic        c_ir, c_ov, c_bz, c_dn;
  int          c_do;

  int          n_chk, n_pass;
  int          ga[9];
  int          gb[9];

  matrix_mult_stream #(.DW(8), .M(2), .K(2), .N(2), .SIGNED(0)) u_sq (
    .clk(clk), .reset(reset), .start(start_b && sel == 0), .data_in(din_b),
    .in_valid(in_valid_b && sel == 0), .in_ready(ir0), .data_out(dout0),
    .out_valid(ov0), .out_ready(out_ready_b && sel == 0), .busy(bz0), .done(dn0));

  matrix_mult_stream #(.DW(8), .M(2), .K(3), .N(1), .SIGNED(0)) u_rect (
    .clk(clk), .reset(reset), .start(start_b && sel == 1), .data_in(din_b),
    .in_valid(in_valid_b && sel == 1), .in_ready(ir1), .data_out(dout1),
    .out_valid(ov1), .out_ready(out_ready_b && sel == 1), .busy(bz1), .done(dn1));

  matrix_mult_stream #(.DW(8), .M(2), .K(2), .N(2), .SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .start(start_b && sel == 2), .data_in(din_b),
    .in_valid(in_valid_b && sel == 2), .in_ready(ir2), .data_out(dout2),
    .out_valid(ov2), .out_ready(out_ready_b && sel == 2), .busy(bz2), .done(dn2));

  always_comb begin
    c_ir = ir0; c_ov = ov0; c_bz = bz0; c_dn = dn0; c_do = int'(dout0);
    case (sel)
      1: begin c_ir = ir1; c_ov = ov1; c_bz = bz1; c_dn = dn1; c_do = int'(dout1); end
      2: begin c_ir = ir2; c_ov = ov2; c_bz = bz2; c_dn = dn2; c_do = int'($signed(dout2)); end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int kdim(input int s);
    return (s == 1) ? 3 : 2;
  endfunction

  function automatic int ndim(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  function automatic int rnd_elem(input int s);
    return (s == 2) ? int'($urandom_range(255)) - 128 : int'($urandom_range(255));
  endfunction

  task automatic run_job(input int s, input int gap_max, input int stall_pct,
                         input int hold_n, input bit poke);
    int m, k, n, len, idx, gap, last_x, first_ov, ndone, held, sum, hn;
    bit prev_stall;
    int stream[$];
    int expq[$];
    m = 2; k = kdim(s); n = ndim(s); hn = hold_n;
    for (int x = 0; x < m * k; x++) stream.push_back(ga[x]);
    for (int x = 0; x < k * n; x++) stream.push_back(gb[x]);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        sum = 0;
        for (int t = 0; t < k; t++) sum += ga[r * k + t] * gb[t * n + c];
        expq.push_back(sum);
      end
    len = stream.size();
    sel = s;
    @(posedge clk); #1;
    start_b = 1'b1; in_valid_b = poke; din_b = 8'hA5; out_ready_b = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b0; in_valid_b = 1'b0;
    check_val("busy_rise", int'(c_bz), 1);
    idx = 0; gap = 0; last_x = -1; first_ov = -1; ndone = 0; held = 0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 3000 && ndone == 0; cyc++) begin
      if (idx < len && gap == 0) begin
        in_valid_b = 1'b1; din_b = 8'(stream[idx]);
      end else begin
        in_valid_b = 1'b0; din_b = 8'h5A;
        if (gap > 0) gap--;
      end
      out_ready_b = (hn > 0) ? 1'b0 : (int'($urandom_range(99)) >= stall_pct);
      start_b = poke ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        check_val("hold_valid", int'(c_ov), 1);
        check_val("hold_data", c_do, held);
      end
      if (in_valid_b && c_ir) begin
        idx++;
        if (idx == len) last_x = cyc;
        gap = gap_max;
      end
      prev_stall = 1'b0;
      if (c_ov) begin
        if (first_ov < 0) begin
          first_ov = cyc;
          check_val("first_latency", first_ov - last_x, k + 1);
        end
        if (out_ready_b) begin
          if (expq.size() == 0) check_val("extra_elem", c_do, -1);
          else check_val("c_elem", c_do, expq.pop_front());
        end else begin
          prev_stall = 1'b1; held = c_do;
          if (hn > 0) hn--;
        end
      end
      if (c_dn) ndone++;
      @(posedge clk); #1;
    end
    start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    check_val("done_seen", ndone, 1);
    check_val("elems_left", expq.size(), 0);
    check_val("busy_fall", int'(c_bz), 0);
    @(negedge clk);
    check_val("done_one_cycle", int'(c_dn), 0);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_in_ready"}, int'(c_ir), 0);
    check_val({tag, "_out_valid"}, int'(c_ov), 0);
    check_val({tag, "_busy"}, int'(c_bz), 0);
    check_val({tag, "_done"}, int'(c_dn), 0);
    check_val({tag, "_data_out"}, c_do, 0);
  endtask

  task automatic abort_job();
    int pulses;
    sel = 0;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int x = 0; x < 6; x++) begin
      in_valid_b = 1'b1;
      din_b = 8'(x < 4 ? ga[x] : gb[x - 4]);
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    reset = 1'b1;
    for (int x = 0; x < 3; x++) begin
      @(negedge clk);
      check_quiet("mid_reset");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int x = 0; x < 5; x++) begin
      @(negedge clk);
      if (c_dn || c_bz) pulses++;
    end
    check_val("post_abort_idle", pulses, 0);
  endtask

  task automatic load_case1();
    ga[0] = 1; ga[1] = 2; ga[2] = 3; ga[3] = 4;
    gb[0] = 4; gb[1] = 3; gb[2] = 2; gb[3] = 1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; sel = 0;
    start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; din_b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    load_case1();
    run_job(0, 0, 0, 0, 1'b0);

    ga[0] = 1; ga[1] = 2; ga[2] = 3; ga[3] = 4; ga[4] = 5; ga[5] = 6;
    gb[0] = 1; gb[1] = 1; gb[2] = 1;
    run_job(1, 2, 0, 0, 1'b0);

    for (int x = 0; x < 4; x++) begin ga[x] = rnd_elem(0); gb[x] = rnd_elem(0); end
    run_job(0, 0, 30, 5, 1'b0);

    ga[0] = -128; ga[1] = -128; ga[2] = 1; ga[3] = -1;
    gb[0] = -128; gb[1] = 0;    gb[2] = -128; gb[3] = 0;
    run_job(2, 0, 0, 0, 1'b0);

    for (int x = 0; x < 4; x++) begin ga[x] = 255; gb[x] = 255; end
    run_job(0, 0, 0, 0, 1'b0);

    load_case1();
    abort_job();
    run_job(0, 0, 0, 0, 1'b0);

    run_job(0, 1, 40, 2, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int x = 0; x < 2 * kdim(r % 3); x++) ga[x] = rnd_elem(r % 3);
      for (int x = 0; x < kdim(r % 3) * ndim(r % 3); x++) gb[x] = rnd_elem(r % 3);
      run_job(r % 3, int'($urandom_range(2)), int'($urandom_range(60)),
              int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
